// File: rtl/passcode_entry_if.sv
// Passcode entry bus: system state and raw keys in, dialled digit, entry progress,
// stored passcode and result pulses out. The package carries the system FSM state
// type shared with the alarm controller.
package passcode_entry_pkg;
  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;
endpackage

interface passcode_entry_if #(
  parameter int NUM_DIGITS = 4
);
  import passcode_entry_pkg::*;

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CODE_W = NUM_DIGITS * 4;

  fsm_state_t        system_state;
  logic              key_up_n;
  logic              key_down_n;
  logic              key_enter_n;
  logic [3:0]        current_value;
  logic [IDX_W-1:0]  digit_index;
  logic [CODE_W-1:0] entered_code;
  logic [CODE_W-1:0] passcode;
  logic              code_ready;
  logic              code_match;
  logic              code_mismatch;

  modport master (
    output system_state, key_up_n, key_down_n, key_enter_n,
    input  current_value, digit_index, entered_code, passcode,
    input  code_ready, code_match, code_mismatch
  );

  modport slave (
    input  system_state, key_up_n, key_down_n, key_enter_n,
    output current_value, digit_index, entered_code, passcode,
    output code_ready, code_match, code_mismatch
  );
endinterface

// File: rtl/passcode_entry.sv
// Passcode entry: debounces the UP/DOWN/ENTER buttons, steps the dialled digit,
// assembles a multi-digit BCD entry and either stores it as the passcode (IDLE)
// or compares it against the stored passcode (TRIGGER/ALERT).
module passcode_entry
  import passcode_entry_pkg::*;
#(
  parameter int                      DEBOUNCE_CYCLES = 500_000,
  parameter int                      NUM_DIGITS      = 4,
  parameter logic [NUM_DIGITS*4-1:0] DEFAULT_CODE    = 16'h1234
) (
  input  logic           clk,
  input  logic           reset,
  passcode_entry_if.slave bus
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int CODE_W = NUM_DIGITS * 4;
  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_ENTER = 2;

  typedef enum logic {DIAL, EVAL} entry_state_t;

  function automatic logic [3:0] digit_inc(input logic [3:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [3:0] digit_dec(input logic [3:0] d);
    return (d == 4'd0 || d > 4'd9) ? 4'd9 : d - 4'd1;
  endfunction

  // Key path: raw active-low buttons, index order {enter, down, up}
  logic [2:0]       raw_n;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       db_pressed;
  logic [2:0]       db_pressed_d;
  logic [CNT_W-1:0] db_cnt [3];
  logic [2:0]       press_evt;

  assign raw_n = {bus.key_enter_n, bus.key_down_n, bus.key_up_n};

  // Two-flop synchronizer into the clock domain; buttons read as released in reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '1;
      sync_p1 <= '1;
    end else begin
      sync_p0 <= raw_n;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: adopt the synchronized level once it has disagreed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_pressed   <= '0;
      db_pressed_d <= '0;
      for (int k = 0; k < 3; k++) db_cnt[k] <= '0;
    end else begin
      db_pressed_d <= db_pressed;
      for (int k = 0; k < 3; k++) begin
        if (~sync_p1[k] == db_pressed[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == CNT_LAST) begin
          db_pressed[k] <= ~sync_p1[k];
          db_cnt[k]     <= '0;
        end else begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // One pulse per released->pressed edge, so a held key never repeats
  assign press_evt = db_pressed & ~db_pressed_d;

  // Entry FSM and datapath
  entry_state_t      state_q, state_n;
  fsm_state_t        sys_prev;
  logic [3:0]        value_q, value_n;
  logic [IDX_W-1:0]  idx_q, idx_n;
  logic [CODE_W-1:0] code_q, code_n;
  logic [CODE_W-1:0] pass_q, pass_n;
  logic              ready_q, ready_n;
  logic              match_q, match_n;
  logic              mismatch_q, mismatch_n;
  logic              abort;
  logic              enter_evt;
  logic              up_evt;
  logic              down_evt;

  // Any change of the system state cancels the entry in progress
  assign abort     = (bus.system_state != sys_prev);
  assign enter_evt = press_evt[KEY_ENTER];
  assign up_evt    = press_evt[KEY_UP]   & ~press_evt[KEY_DOWN] & ~enter_evt;
  assign down_evt  = press_evt[KEY_DOWN] & ~press_evt[KEY_UP]   & ~enter_evt;

  // State and output registers; result pulses appear the cycle after EVAL
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DIAL;
      sys_prev   <= STATE_IDLE;
      value_q    <= '0;
      idx_q      <= '0;
      code_q     <= '0;
      pass_q     <= DEFAULT_CODE;
      ready_q    <= 1'b0;
      match_q    <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_n;
      sys_prev   <= bus.system_state;
      value_q    <= value_n;
      idx_q      <= idx_n;
      code_q     <= code_n;
      pass_q     <= pass_n;
      ready_q    <= ready_n;
      match_q    <= match_n;
      mismatch_q <= mismatch_n;
    end
  end

  // Next state: abort has priority, EVAL ignores keys, DIAL applies ENTER over UP/DOWN
  always_comb begin
    state_n    = state_q;
    value_n    = value_q;
    idx_n      = idx_q;
    code_n     = code_q;
    pass_n     = pass_q;
    ready_n    = 1'b0;
    match_n    = 1'b0;
    mismatch_n = 1'b0;
    if (abort) begin
      state_n = DIAL;
      value_n = '0;
      idx_n   = '0;
      code_n  = '0;
    end else if (state_q == EVAL) begin
      ready_n = 1'b1;
      case (bus.system_state)
        STATE_IDLE: pass_n = code_q;
        STATE_TRIGGER, STATE_ALERT: begin
          if (code_q == pass_q) match_n = 1'b1;
          else                  mismatch_n = 1'b1;
        end
        default: ;
      endcase
      code_n  = '0;
      idx_n   = '0;
      state_n = DIAL;
    end else begin
      if (enter_evt) begin
        // Digit 0 occupies the most significant nibble
        for (int d = 0; d < NUM_DIGITS; d++) begin
          if (d == int'(idx_q)) code_n[(NUM_DIGITS-1-d)*4 +: 4] = value_q;
        end
        value_n = '0;
        if (idx_q == LAST_IDX) state_n = EVAL;
        else                   idx_n   = idx_q + 1'b1;
      end else if (up_evt) begin
        value_n = digit_inc(value_q);
      end else if (down_evt) begin
        value_n = digit_dec(value_q);
      end
    end
  end

  assign bus.current_value = value_q;
  assign bus.digit_index   = idx_q;
  assign bus.entered_code  = code_q;
  assign bus.passcode      = pass_q;
  assign bus.code_ready    = ready_q;
  assign bus.code_match    = match_q;
  assign bus.code_mismatch = mismatch_q;

endmodule
